// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: picks exception/branch/jump/PC+4 and holds on stalls.
// Optional exception path enabled by defining PC_FETCH_EXC_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic        imem_ready_i,
    input  logic        hazard_stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
`ifdef PC_FETCH_EXC_EN
    input  logic        exc_req_i,
    input  logic [31:0] exc_epc_i,
    output logic [31:0] epc_o,
`endif
    output logic        keep_o,
    output logic [31:0] pc_next_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [1:0] SRC_JMP = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_EXC = 2'd2;

`ifdef PC_FETCH_EXC_EN
    localparam logic [31:0] EXC_VEC = 32'h8000_0180;
`endif

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]  pend_src_q, pend_src_d;
    logic [15:0] stall_cnt_q;

    logic        cand_vld;
    logic [1:0]  cand_src;
    logic [31:0] cand_tgt;
    logic        overwrite;
    logic        accept;

    always_comb begin
        cand_vld = 1'b0;
        cand_src = SRC_JMP;
        cand_tgt = jmp_target_i;
        if (br_taken_i) begin
            cand_vld = 1'b1;
            cand_src = SRC_BR;
            cand_tgt = br_target_i;
        end else if (jmp_valid_i && !hazard_stall_i) begin
            cand_vld = 1'b1;
            cand_src = SRC_JMP;
            cand_tgt = jmp_target_i;
        end
`ifdef PC_FETCH_EXC_EN
        if (exc_req_i) begin
            cand_vld = 1'b1;
            cand_src = SRC_EXC;
            cand_tgt = EXC_VEC;
        end
`endif
    end

    // A newer branch is the successor of the pending one's instruction, so equal-rank BR wins.
    assign overwrite = cand_vld &&
                       ((cand_src > pend_src_q) || (cand_src == SRC_BR && pend_src_q == SRC_BR));

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pend_src_d = pend_src_q;
        keep_o     = 1'b1;
        pc_next_o  = pc_i;
        accept     = 1'b0;
        case (state_q)
            S_RUN, S_WAIT: begin
                if (imem_ready_i) begin
                    state_d = S_RUN;
                    if (cand_vld) begin
                        keep_o    = 1'b0;
                        pc_next_o = cand_tgt;
                        accept    = 1'b1;
                    end else if (!hazard_stall_i) begin
                        keep_o    = 1'b0;
                        pc_next_o = pc4_i;
                    end
                end else if (cand_vld) begin
                    accept     = 1'b1;
                    pend_tgt_d = cand_tgt;
                    pend_src_d = cand_src;
                    state_d    = S_PEND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_PEND: begin
                if (overwrite) begin
                    accept     = 1'b1;
                    pend_tgt_d = cand_tgt;
                    pend_src_d = cand_src;
                end
                if (imem_ready_i) begin
                    keep_o    = 1'b0;
                    pc_next_o = overwrite ? cand_tgt : pend_tgt_q;
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        flush_if_o = accept;
        flush_id_o = accept && (cand_src != SRC_JMP);

        if (rst) begin
            keep_o     = 1'b1;
            pc_next_o  = RESET_VEC;
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            pend_tgt_q  <= 32'h0;
            pend_src_q  <= SRC_JMP;
            stall_cnt_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            pend_src_q <= pend_src_d;
            if (keep_o && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

`ifdef PC_FETCH_EXC_EN
    logic [31:0] epc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            epc_q <= 32'h0;
        else if (accept && cand_src == SRC_EXC)
            epc_q <= exc_epc_i;
    end

    assign epc_o = epc_q;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage controller that sequences the PC register. Each cycle it chooses the next fetch address from the exception vector, EX-stage branch, ID-stage jump or the sequential PC+4, in that priority order. It holds the PC during load-use hazards and instruction-memory wait states. A redirect that arrives while a fetch is still outstanding is latched and applied once the fetch completes; the IF/ID flush strobes are issued at the moment the redirect is accepted.

## Interface
- RESET_VEC, 32'h0000_0000: value driven on pc_next while rst is high.
- EXC_VEC, 32'h8000_0180: exception handler entry address.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc  in  32  current PC register value.
- pc4  in  32  pc + 4 from the PC register.
- imem_ready  in  1  instruction word for pc is available this cycle.
- hazard_stall  in  1  load-use stall from the hazard unit.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  32  branch target.
- jmp_valid  in  1  ID-stage J/JAL/JR decoded.
- jmp_target  in  32  jump target.
- exc_req  in  1  exception request from the commit stage (present only with PC_FETCH_EXC_EN).
- exc_epc  in  32  faulting PC (present only with PC_FETCH_EXC_EN).
- keep  out  1  drives the PC register hold input; 1 = hold.
- pc_next  out  32  next-PC value for the PC register.
- flush_if  out  1  squash the instruction in IF/ID.
- flush_id  out  1  squash the instruction in ID/EX.
- epc  out  32  latched exception PC (present only with PC_FETCH_EXC_EN).
- stall_cnt  out  16  count of cycles with keep = 1; saturates at 16'hFFFF.

## Operation
- FSM states:
  - RUN (reset state): fetch completing normally.
  - WAIT: fetch outstanding, no redirect captured.
  - PEND: fetch outstanding, redirect captured in pend_tgt / pend_src.
- Candidate redirect each cycle, highest priority first: exc_req, br_taken, jmp_valid (only when hazard_stall = 0).
- Source ranks: EXC = 2, BR = 1, JMP = 0.

RUN / WAIT:
- imem_ready = 1 and a candidate exists:
  - keep = 0, pc_next = candidate target, next state RUN.
- imem_ready = 1, no candidate, hazard_stall = 0:
  - keep = 0, pc_next = pc4.
- imem_ready = 1, no candidate, hazard_stall = 1:
  - keep = 1, pc_next = pc.
- imem_ready = 0:
  - keep = 1.
  - A candidate is latched into pend_tgt / pend_src; next state PEND.
  - Otherwise next state WAIT.

PEND:
- keep = 1 until imem_ready = 1.
- On imem_ready = 1: keep = 0, pc_next = pend_tgt, next state RUN, hazard_stall ignored.
- A new candidate of strictly higher rank overwrites the pending redirect.
- An equal-rank BR overwrites (the newer branch is the older instruction's successor, so it wins).
- Lower-rank candidates are dropped.
- If imem_ready = 1 and a higher-rank candidate arrives in the same cycle, the candidate is used directly.

Branch vs. stall:
- A branch overrides hazard_stall.
- A jump is not accepted under hazard_stall; the ID instruction re-presents it.

Flushes (combinational, asserted in the acceptance cycle, whether applied or latched):
- EXC: flush_if = 1, flush_id = 1.
- BR: flush_if = 1, flush_id = 1.
- JMP: flush_if = 1.
- Flushes are re-asserted if a pending redirect is overwritten.

stall_cnt:
- Increments on every cycle with keep = 1 and rst = 0.
- Cleared only by rst.

## Timing
- keep, pc_next and flush outputs are combinational from state and inputs; the PC register captures pc_next on the same edge.
- Redirect latency:
  - Target appears on pc when the fetch is complete: 1 edge after acceptance.
  - Otherwise 1 edge after imem_ready rises.
- FSM, pend_tgt, pend_src, epc and stall_cnt are registered.
- While rst = 1:
  - State = RUN, pend cleared.
  - keep = 1, pc_next = RESET_VEC.
  - flush_if = flush_id = 1.
  - epc = 0, stall_cnt = 0.
- Reset mid-PEND discards the pending redirect; the first cycle after release behaves as RUN.

## Configuration
- PC_FETCH_EXC_EN defined:
  - exc_req, exc_epc and epc exist.
  - Accepting an exception loads epc <= exc_epc and redirects to EXC_VEC.
- PC_FETCH_EXC_EN undefined:
  - Those ports and the epc register are removed.
  - Rank EXC never occurs; everything else is identical.

## Test plan
- Reset, then imem_ready = 1 with no requests: pc_next runs 0x0, 0x4, 0x8 …; keep = 0; stall_cnt = 0.
- pc = 0x40, hazard_stall = 1 for 2 cycles: keep = 1 for both cycles; pc stays 0x40; stall_cnt = 2; next pc = 0x44.
- pc = 0x40, imem_ready = 0, jmp_valid with target 0x100, then br_taken with target 0x200 one cycle later, imem_ready = 1 on the 3rd cycle:
  - flush_if is asserted in both acceptance cycles.
  - The jump is overwritten by the branch.
  - pc becomes 0x200, never 0x100.
- br_taken with target 0x80 and jmp_valid with target 0x90 in the same cycle, imem_ready = 1: pc_next = 0x80; flush_if = flush_id = 1.
- With PC_FETCH_EXC_EN: exc_req with exc_epc = 0x1234 while a branch is pending: pc → 0x8000_0180; epc = 0x1234; flush_if = flush_id = 1.
- rst asserted while in PEND with target 0x300: after release pc_next = 0x4 sequence from 0x0; 0x300 never appears.
